// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared states, line levels and parity helper for the serial frame receiver
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;

    // Widest frame the receiver supports; the parity helper works on this width.
    localparam int MAX_WIDTH = 16;

    // XOR of all bits; narrower words are zero-extended, which leaves parity unchanged.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - serial line in, parallel word and status out
//
// Signals:
//   ip         serial line (idle 0)
//   data       last received word, bit 0 received first
//   valid      one-cycle strobe on frame completion
//   parity_err parity mismatch on the last frame
//   frame_err  stop bit of the last frame was 1
//   busy       receiver is inside a frame
// Modports: master drives the line and observes results; slave is the receiver.
interface serial_frame_receiver_if #(
    parameter int WIDTH = 8
);
    logic             ip;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    modport master (
        output ip,
        input  data, valid, parity_err, frame_err, busy
    );

    modport slave (
        input  ip,
        output data, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_frame_receiver_sipo_shift_reg.sv
// rtl/serial_frame_receiver_sipo_shift_reg.sv - serial-in/parallel-out register, LSB-first assembly
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       synchronous clear (wins over shift_en)
//   shift_en    shift din in at the MSB end, moving existing bits toward bit 0
//   din         serial input bit
//   q           parallel contents
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - start-bit framed serial receiver with even parity and stop check
//
// Ports:
//   clk    system clock, line sampled on rising edge
//   reset  asynchronous active-high reset
//   bus    slave side of serial_frame_receiver_if (ip in; data/valid/flags/busy out)
// Parameters:
//   WIDTH      data bits per frame (2..16)
//   PARITY_EN  1 = an even-parity bit follows the data bits
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_frame_receiver_if.slave  bus
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    bit_cnt;
    logic             par_bit;
    logic [WIDTH-1:0] shreg;
    logic             start;
    logic             shift_en;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .clear    (start),
        .shift_en (shift_en),
        .din      (bus.ip),
        .q        (shreg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ip == START_LEVEL) begin
                    next_state = DATA;
                    start      = 1'b1;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    next_state = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: next_state = STOP;
            // The stop bit is always consumed here, so a 1 can never double as a start.
            STOP:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (start) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (state == PARITY) begin
            par_bit <= bus.ip;
        end
    end

    // Results are captured on the stop-bit edge; by then the last data bit is already in shreg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data       <= '0;
            bus.valid      <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.valid <= (state == STOP);
            bus.busy  <= (next_state != IDLE);
            if (state == STOP) begin
                bus.data       <= shreg;
                bus.frame_err  <= bus.ip;
                bus.parity_err <= (PARITY_EN != 0)
                                  ? (even_parity(MAX_WIDTH'(shreg)) ^ par_bit)
                                  : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - directed self-checking bench for serial_frame_receiver
module tb_serial_frame_receiver;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_frame_receiver_if #(.WIDTH(8)) if0 ();
    serial_frame_receiver_if #(.WIDTH(8)) if1 ();

    serial_frame_receiver #(.WIDTH(8), .PARITY_EN(1)) dut_par (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    serial_frame_receiver #(.WIDTH(8), .PARITY_EN(0)) dut_nopar (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic vld(input int which);
        return (which == 0) ? if0.valid : if1.valid;
    endfunction

    function automatic logic bsy(input int which);
        return (which == 0) ? if0.busy : if1.busy;
    endfunction

    function automatic logic [7:0] dat(input int which);
        return (which == 0) ? if0.data : if1.data;
    endfunction

    // Present one bit, let it be sampled, then settle 1 time unit past the edge.
    task automatic drive_bit(input int which, input logic b);
        if (which == 0) if0.ip = b;
        else            if1.ip = b;
        @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB-first, parity (parity instance only), stop bit.
    task automatic run_frame(input string tag, input int which, input logic [7:0] w,
                             input logic par, input logic stop);
        int early;
        drive_bit(which, 1'b1);
        early = int'(vld(which));
        check({tag, " busy_after_start"}, 32'(bsy(which)), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive_bit(which, w[i]);
            early += int'(vld(which));
        end
        if (which == 0) begin
            drive_bit(0, par);
            early += int'(vld(0));
        end
        drive_bit(which, stop);
        check({tag, " early_valid"}, 32'(early), 32'd0);
        check({tag, " valid"}, 32'(vld(which)), 32'd1);
        check({tag, " data"}, 32'(dat(which)), 32'(w));
        check({tag, " busy_after_stop"}, 32'(bsy(which)), 32'd0);
    endtask

    initial begin
        int seen;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if0.ip   = 1'b0;
        if1.ip   = 1'b0;
        #12;
        check("reset data", 32'(if0.data), 32'h0);
        check("reset flags", {28'h0, if0.valid, if0.busy, if0.parity_err, if0.frame_err}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle line: nothing may move on either instance.
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive_bit(0, 1'b0);
            seen += int'(if0.valid | if0.busy | if0.parity_err | if0.frame_err);
            seen += int'(if1.valid | if1.busy | if1.parity_err | if1.frame_err);
        end
        check("idle activity", 32'(seen), 32'd0);
        check("idle data", 32'(if0.data), 32'h0);

        // Good frame 0xA5, parity 0 (four ones), stop 0.
        run_frame("good", 0, 8'hA5, 1'b0, 1'b0);
        check("good parity_err", 32'(if0.parity_err), 32'd0);
        check("good frame_err", 32'(if0.frame_err), 32'd0);
        drive_bit(0, 1'b0);
        check("good valid_one_cycle", 32'(if0.valid), 32'd0);
        check("good data_hold", 32'(if0.data), 32'hA5);

        // Wrong parity bit.
        run_frame("perr", 0, 8'hA5, 1'b1, 1'b0);
        check("perr parity_err", 32'(if0.parity_err), 32'd1);
        check("perr frame_err", 32'(if0.frame_err), 32'd0);
        drive_bit(0, 1'b0);

        // Back-to-back: second start on the edge right after the first stop.
        run_frame("b2b_a", 0, 8'hA5, 1'b0, 1'b0);
        check("b2b_a parity_err", 32'(if0.parity_err), 32'd0);
        run_frame("b2b_b", 0, 8'h3C, 1'b0, 1'b0);
        check("b2b_b parity_err", 32'(if0.parity_err), 32'd0);
        check("b2b_b frame_err", 32'(if0.frame_err), 32'd0);
        drive_bit(0, 1'b0);

        // Stop bit 1: flagged, still delivered, not taken as a new start.
        run_frame("ferr", 0, 8'hA5, 1'b0, 1'b1);
        check("ferr frame_err", 32'(if0.frame_err), 32'd1);
        check("ferr parity_err", 32'(if0.parity_err), 32'd0);
        drive_bit(0, 1'b0);
        check("ferr idle_after", {30'h0, if0.busy, if0.valid}, 32'h0);

        // Reset asserted between edges four bits into a frame.
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        check("midrst busy_before", 32'(if0.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst data", 32'(if0.data), 32'h0);
        check("midrst flags", {28'h0, if0.valid, if0.busy, if0.parity_err, if0.frame_err}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        if0.ip = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            drive_bit(0, 1'b0);
            seen += int'(if0.valid | if0.busy);
        end
        check("midrst no_valid", 32'(seen), 32'd0);
        run_frame("after_rst", 0, 8'h5A, 1'b0, 1'b0);
        check("after_rst parity_err", 32'(if0.parity_err), 32'd0);
        check("after_rst frame_err", 32'(if0.frame_err), 32'd0);
        drive_bit(0, 1'b0);

        // No-parity instance: stop sampled at k+9.
        run_frame("nopar", 1, 8'hFF, 1'b0, 1'b0);
        check("nopar parity_err", 32'(if1.parity_err), 32'd0);
        check("nopar frame_err", 32'(if1.frame_err), 32'd0);
        drive_bit(1, 1'b0);
        check("nopar valid_one_cycle", 32'(if1.valid), 32'd0);
        run_frame("nopar2", 1, 8'h07, 1'b0, 1'b1);
        check("nopar2 parity_err", 32'(if1.parity_err), 32'd0);
        check("nopar2 frame_err", 32'(if1.frame_err), 32'd1);
        check("nopar other_dut_quiet", 32'(if0.data), 32'h5A);
        drive_bit(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
